// File: rtl/warp_issue_scheduler_pkg.sv
// Shared constants and types for the warp issue path (scheduler, IBuffer, scoreboard).
package warp_issue_scheduler_pkg;

  localparam int unsigned NUM_WARPS = 8;
  localparam int unsigned WARP_ID_W = 3;

  // Issue descriptor field widths: valid + warp index + replay flag.
  localparam int unsigned ISSUE_VALID_W  = 1;
  localparam int unsigned ISSUE_REPLAY_W = 1;
  localparam int unsigned ISSUE_DESC_W   = ISSUE_VALID_W + WARP_ID_W + ISSUE_REPLAY_W;

  // Which priority level produced this cycle's grant.
  typedef enum logic [1:0] {
    GrantNone,
    GrantReplay,
    GrantNew,
    GrantStarve
  } grant_kind_e;

  // Slot visited at offset 'off' when scanning round-robin from 'base'.
  function automatic int unsigned rr_slot(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

  // Replays always use the memory path; new issues only when the head is LW/SW.
  function automatic logic grant_is_mem(grant_kind_e kind, logic head_replayable);
    return (kind == GrantReplay) ||
           (((kind == GrantNew) || (kind == GrantStarve)) && head_replayable);
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping to 0.
module warp_issue_scheduler_rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  import warp_issue_scheduler_pkg::*;

  logic             found;
  logic [IDX_W-1:0] slot;

  // Scan N slots starting at ptr; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      slot = IDX_W'(rr_slot(32'(ptr), i, N));
      if (!found && req[slot]) begin
        found     = 1'b1;
        gnt[slot] = 1'b1;
        idx       = slot;
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Per-cycle issue arbiter: replay > starving new issue > round-robin new issue,
// with a cooldown between memory-class grants and a registered issue descriptor.
module warp_issue_scheduler #(
  parameter int unsigned NUM_WARPS    = warp_issue_scheduler_pkg::NUM_WARPS,
  parameter int unsigned WARP_ID_W    = warp_issue_scheduler_pkg::WARP_ID_W,
  parameter int unsigned MEM_GAP      = 2,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] IB_Valid,
  input  logic [NUM_WARPS-1:0] IB_Replayable,
  input  logic [NUM_WARPS-1:0] Scb_Dependent,
  input  logic [NUM_WARPS-1:0] Scb_Full,
  input  logic [NUM_WARPS-1:0] Replay_Req,
  input  logic                 Mem_Busy,
  input  logic                 Issue_Stall,
  output logic [NUM_WARPS-1:0] RP_Grt,
  output logic [NUM_WARPS-1:0] Replay_Grt,
  output logic                 Issue_Valid,
  output logic [WARP_ID_W-1:0] Issue_WarpID,
  output logic                 Issue_Replay
);
  import warp_issue_scheduler_pkg::*;

  // Keep at least one bit so MEM_GAP=0 still elaborates (counter then stays 0).
  localparam int unsigned GapW    = (MEM_GAP > 0) ? $clog2(MEM_GAP + 1) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  // State
  logic [WARP_ID_W-1:0]              rep_ptr_q;
  logic [WARP_ID_W-1:0]              new_ptr_q;
  logic [GapW-1:0]                   gap_q;
  logic [NUM_WARPS-1:0][StarveW-1:0] starve_q;
  logic                              issue_valid_q;
  logic [WARP_ID_W-1:0]              issue_warp_id_q;
  logic                              issue_replay_q;

  // Eligibility
  logic                 active;
  logic                 mem_block;
  logic [NUM_WARPS-1:0] new_elig;
  logic [NUM_WARPS-1:0] rep_elig;
  logic [NUM_WARPS-1:0] starving;
  logic [NUM_WARPS-1:0] starve_req;

  // Arbitration results
  logic [NUM_WARPS-1:0] rep_gnt;
  logic [WARP_ID_W-1:0] rep_idx;
  logic [NUM_WARPS-1:0] new_gnt;
  logic [WARP_ID_W-1:0] new_idx;
  logic [NUM_WARPS-1:0] starve_gnt;
  logic [WARP_ID_W-1:0] starve_idx;
  logic                 starve_found;

  grant_kind_e          grant_kind;
  logic [WARP_ID_W-1:0] grant_idx;
  logic [WARP_ID_W-1:0] grant_idx_inc;
  logic [NUM_WARPS-1:0] rp_grt;
  logic [NUM_WARPS-1:0] replay_grt;
  logic [NUM_WARPS-1:0] granted;
  logic                 grant_mem;

  // Eligibility masks; reset and stall suppress every grant.
  always_comb begin
    active     = rst & ~Issue_Stall;
    mem_block  = Mem_Busy | (gap_q != '0);
    new_elig   = IB_Valid & ~Scb_Dependent & ~Scb_Full &
                 ~(IB_Replayable & {NUM_WARPS{mem_block}}) & {NUM_WARPS{active}};
    rep_elig   = Replay_Req & {NUM_WARPS{~mem_block}} & {NUM_WARPS{active}};
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      starving[w] = (starve_q[w] == StarveW'(STARVE_LIMIT));
    end
    starve_req = new_elig & starving;
  end

  warp_issue_scheduler_rr_arbiter #(
    .N    (NUM_WARPS),
    .IDX_W(WARP_ID_W)
  ) u_rep_arb (
    .req(rep_elig),
    .ptr(rep_ptr_q),
    .gnt(rep_gnt),
    .idx(rep_idx)
  );

  warp_issue_scheduler_rr_arbiter #(
    .N    (NUM_WARPS),
    .IDX_W(WARP_ID_W)
  ) u_new_arb (
    .req(new_elig),
    .ptr(new_ptr_q),
    .gnt(new_gnt),
    .idx(new_idx)
  );

  // Starvation override picks the lowest-index starving warp, not round-robin.
  always_comb begin
    starve_gnt   = '0;
    starve_idx   = '0;
    starve_found = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (!starve_found && starve_req[w]) begin
        starve_found  = 1'b1;
        starve_gnt[w] = 1'b1;
        starve_idx    = WARP_ID_W'(w);
      end
    end
  end

  // Priority select across the three request classes; at most one grant bit overall.
  always_comb begin
    grant_kind = GrantNone;
    grant_idx  = '0;
    rp_grt     = '0;
    replay_grt = '0;
    if (|rep_elig) begin
      grant_kind = GrantReplay;
      grant_idx  = rep_idx;
      replay_grt = rep_gnt;
    end else if (|starve_req) begin
      grant_kind = GrantStarve;
      grant_idx  = starve_idx;
      rp_grt     = starve_gnt;
    end else if (|new_elig) begin
      grant_kind = GrantNew;
      grant_idx  = new_idx;
      rp_grt     = new_gnt;
    end
    granted       = rp_grt | replay_grt;
    grant_mem     = grant_is_mem(grant_kind, IB_Replayable[grant_idx]);
    grant_idx_inc = (grant_idx == WARP_ID_W'(NUM_WARPS - 1)) ? '0
                                                             : grant_idx + WARP_ID_W'(1);
  end

  assign RP_Grt     = rp_grt;
  assign Replay_Grt = replay_grt;

  // Round-robin pointers advance past the granted warp; hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_ptr_q <= '0;
      new_ptr_q <= '0;
    end else begin
      if (grant_kind == GrantReplay) begin
        rep_ptr_q <= grant_idx_inc;
      end
      if ((grant_kind == GrantNew) || (grant_kind == GrantStarve)) begin
        new_ptr_q <= grant_idx_inc;
      end
    end
  end

  // Memory cooldown: reload on a memory-class grant, otherwise drain (even under stall).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= '0;
    end else if (grant_mem) begin
      gap_q <= GapW'(MEM_GAP);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - GapW'(1);
    end
  end

  // Per-warp starvation counters: count passed-over eligible cycles, freeze during stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (!Issue_Stall) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (!new_elig[w] || granted[w]) begin
          starve_q[w] <= '0;
        end else if (!starving[w]) begin
          starve_q[w] <= starve_q[w] + StarveW'(1);
        end
      end
    end
  end

  // Issue descriptor, one cycle behind the grant; warp index holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_q   <= 1'b0;
      issue_warp_id_q <= '0;
      issue_replay_q  <= 1'b0;
    end else begin
      issue_valid_q  <= (grant_kind != GrantNone);
      issue_replay_q <= (grant_kind == GrantReplay);
      if (grant_kind != GrantNone) begin
        issue_warp_id_q <= grant_idx;
      end
    end
  end

  assign Issue_Valid  = issue_valid_q;
  assign Issue_WarpID = issue_warp_id_q;
  assign Issue_Replay = issue_replay_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed table-driven bench for warp_issue_scheduler (MEM_GAP=2, STARVE_LIMIT=3).
module tb_warp_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ib_valid, ib_repl, scb_dep, scb_full, rep_req;
  logic       mem_busy, issue_stall;
  logic [7:0] rp_grt, replay_grt;
  logic       issue_valid, issue_replay;
  logic [2:0] issue_warp_id;

  int n_tests = 0;
  int n_fail  = 0;

  warp_issue_scheduler #(
    .NUM_WARPS   (8),
    .WARP_ID_W   (3),
    .MEM_GAP     (2),
    .STARVE_LIMIT(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IB_Valid     (ib_valid),
    .IB_Replayable(ib_repl),
    .Scb_Dependent(scb_dep),
    .Scb_Full     (scb_full),
    .Replay_Req   (rep_req),
    .Mem_Busy     (mem_busy),
    .Issue_Stall  (issue_stall),
    .RP_Grt       (rp_grt),
    .Replay_Grt   (replay_grt),
    .Issue_Valid  (issue_valid),
    .Issue_WarpID (issue_warp_id),
    .Issue_Replay (issue_replay)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; exp_iv/id/ir are the registered outputs seen in that
  // cycle, i.e. they describe the grant of the previous row.
  typedef struct {
    logic       rst_first;
    logic [7:0] valid, repl, dep, full, rep;
    logic       busy, stall;
    logic [7:0] exp_rp, exp_rep;
    logic       exp_iv;
    logic [2:0] exp_id;
    logic       exp_ir;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  function automatic vec_t mk(logic r, logic [7:0] va, logic [7:0] rl, logic [7:0] dp,
                              logic [7:0] fl, logic [7:0] rq, logic b, logic s,
                              logic [7:0] erp, logic [7:0] erep, logic eiv,
                              logic [2:0] eid, logic eir);
    vec_t t;
    t.rst_first = r;  t.valid = va; t.repl = rl; t.dep = dp; t.full = fl; t.rep = rq;
    t.busy = b; t.stall = s; t.exp_rp = erp; t.exp_rep = erep;
    t.exp_iv = eiv; t.exp_id = eid; t.exp_ir = eir;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] rl, input logic [7:0] dp,
                       input logic [7:0] fl, input logic [7:0] rq, input logic b,
                       input logic s);
    ib_valid = va; ib_repl = rl; scb_dep = dp; scb_full = fl; rep_req = rq;
    mem_busy = b; issue_stall = s;
  endtask

  task automatic do_reset();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Round-robin over warps 0,3,5 with wrap back to 0.
    vecs.push_back(mk(1'b1, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0));
    // Replay beats new issue, even for the same warp.
    vecs.push_back(mk(1'b1, 8'h06, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 1'b1));
    // Memory gap: two LW heads, second waits two cycles.
    vecs.push_back(mk(1'b1, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b0));
    // Scoreboard masking, then Mem_Busy blocking LW head and replay.
    vecs.push_back(mk(1'b1, 8'hFF, 8'h00, 8'h0F, 8'h30, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h44, 8'h04, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b1));
    // Starvation: warp 7 passed over 3 times, then forced ahead of warp 5; pointer wraps.
    vecs.push_back(mk(1'b1, 8'h82, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 3'd3, 1'b1));
    vecs.push_back(mk(1'b0, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 3'd7, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0));
    // Stall for 3 cycles, then warp 4 issues; WarpID holds after.
    vecs.push_back(mk(1'b1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4, 1'b0));
    // Single requester is granted every cycle.
    vecs.push_back(mk(1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst_first) do_reset();
      drive(v.valid, v.repl, v.dep, v.full, v.rep, v.busy, v.stall);
      #1;
      chk("RP_Grt", i, rp_grt, v.exp_rp);
      chk("Replay_Grt", i, replay_grt, v.exp_rep);
      chk("Issue_Valid", i, 8'(issue_valid), 8'(v.exp_iv));
      chk("Issue_WarpID", i, 8'(issue_warp_id), 8'(v.exp_id));
      chk("Issue_Replay", i, 8'(issue_replay), 8'(v.exp_ir));
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted mid-cycle while warp 6 is being granted.
    do_reset();
    drive(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ib_valid = 8'h40;
    #1;
    chk("mid_rst_pre_grant", -1, rp_grt, 8'h40);
    chk("mid_rst_pre_valid", -1, 8'(issue_valid), 8'h01);
    chk("mid_rst_pre_id", -1, 8'(issue_warp_id), 8'h01);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", -1, rp_grt, 8'h00);
    chk("mid_rst_valid", -1, 8'(issue_valid), 8'h00);
    chk("mid_rst_id", -1, 8'(issue_warp_id), 8'h00);
    @(posedge clk);
    #1;
    chk("mid_rst_edge_valid", -1, 8'(issue_valid), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    ib_valid = 8'h81;
    #1;
    chk("post_rst_grant", -1, rp_grt, 8'h01);
    @(posedge clk);
    #1;
    chk("post_rst_valid", -1, 8'(issue_valid), 8'h01);
    chk("post_rst_id", -1, 8'(issue_warp_id), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
